// File: rtl/access_arbiter.sv
// access_arbiter: two-requester arbiter that serialises single register
// transactions onto a downstream write port and a downstream read port.
// A transaction passes through IDLE -> ISSUE -> DONE. While it waits in
// ISSUE, a stall counter limits how long it may wait on a ready signal that
// stays low; when the limit is reached the transaction is aborted and
// reported with err.
// Optional feature: define ACCESS_ARBITER_RR_EN to resolve simultaneous
// requests round-robin. By default r0 has fixed priority.
module access_arbiter #(
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       r0_req,
    input  logic       r0_we,
    input  logic [2:0] r0_addr,
    input  logic       r0_wdata,
    output logic       r0_ack,
    output logic       r0_rdata,
    output logic       r0_err,
    input  logic       r1_req,
    input  logic       r1_we,
    input  logic [2:0] r1_addr,
    input  logic       r1_wdata,
    output logic       r1_ack,
    output logic       r1_rdata,
    output logic       r1_err,
    output logic [2:0] write_address,
    output logic       write_data,
    output logic       write_en,
    input  logic       write_rdy,
    output logic [2:0] read_address,
    output logic       read_en,
    input  logic       read_data,
    input  logic       read_rdy,
    output logic       busy,
    output logic       grant
);

    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       we_q, we_d;
    logic [2:0] addr_q, addr_d;
    logic       wdata_q, wdata_d;
    logic [7:0] stall_q, stall_d;
    logic       rdata_q, rdata_d;
    logic       err_q, err_d;
    logic       sel;

    // Choose which requester wins when the arbiter is idle
    always_comb begin
        sel = 1'b0;
`ifdef ACCESS_ARBITER_RR_EN
        if (r0_req && r1_req) begin
            sel = ~grant_q;
        end else begin
            sel = ~r0_req;
        end
`else
        sel = ~r0_req;
`endif
    end

    // State and latched transaction registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 3'd0;
            wdata_q <= 1'b0;
            stall_q <= 8'd0;
            rdata_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            stall_q <= stall_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and all downstream/requester outputs
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        stall_d       = stall_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        write_address = 3'd0;
        write_data    = 1'b0;
        write_en      = 1'b0;
        read_address  = 3'd0;
        read_en       = 1'b0;
        r0_ack        = 1'b0;
        r0_rdata      = 1'b0;
        r0_err        = 1'b0;
        r1_ack        = 1'b0;
        r1_rdata      = 1'b0;
        r1_err        = 1'b0;

        case (state_q)
            IDLE: begin
                stall_d = 8'd0;
                if (r0_req || r1_req) begin
                    grant_d = sel;
                    we_d    = sel ? r1_we    : r0_we;
                    addr_d  = sel ? r1_addr  : r0_addr;
                    wdata_d = sel ? r1_wdata : r0_wdata;
                    rdata_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                write_address = addr_q;
                write_data    = wdata_q;
                read_address  = addr_q;
                if ((we_q && write_rdy) || (!we_q && read_rdy)) begin
                    write_en = we_q;
                    read_en  = ~we_q;
                    rdata_d  = we_q ? 1'b0 : read_data;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else begin
                    stall_d = stall_q + 8'd1;
                    if (stall_q + 8'd1 == LIMIT) begin
                        rdata_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                r0_ack   = ~grant_q;
                r0_rdata = ~grant_q & rdata_q;
                r0_err   = ~grant_q & err_q;
                r1_ack   = grant_q;
                r1_rdata = grant_q & rdata_q;
                r1_err   = grant_q & err_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign grant = grant_q;

endmodule

// File: tb/tb_access_arbiter.sv
// Testbench for access_arbiter: directed scenarios followed by random
// traffic. Each cycle's outputs are compared against a transaction-level
// reference model.
module tb_access_arbiter;

    localparam int LIMIT = 15;

    logic       CLK = 1'b0;
    logic       RST;
    logic       r0_req, r0_we, r0_wdata, r0_ack, r0_rdata, r0_err;
    logic [2:0] r0_addr;
    logic       r1_req, r1_we, r1_wdata, r1_ack, r1_rdata, r1_err;
    logic [2:0] r1_addr;
    logic [2:0] write_address, read_address;
    logic       write_data, write_en, write_rdy;
    logic       read_en, read_data, read_rdy;
    logic       busy, grant;

    access_arbiter #(.STALL_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .write_address(write_address), .write_data(write_data),
        .write_en(write_en), .write_rdy(write_rdy),
        .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy),
        .busy(busy), .grant(grant)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       we;
        logic [2:0] addr;
        logic       wdata;
    } txn_t;

    // Pending transactions per requester, oldest first
    txn_t q0[$];
    txn_t q1[$];
    bit   cool0, cool1;

    // -1 means randomize each cycle, otherwise the forced value
    int forceWr, forceRd, forceRdData;

    // Reference model: the transaction currently owned by the arbiter
    bit   mActive, mFinished, mOwner, mLastGrant, mErr, mRdata;
    int   mStall;
    txn_t mCur;

    int compared, mismatched;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pickBit(input int f);
        if (f < 0) return ($urandom_range(0, 3) != 0);
        return f[0];
    endfunction

    task automatic applyStimulus();
        txn_t t0, t1;
        t0 = '0;
        t1 = '0;
        if (q0.size() > 0) t0 = q0[0];
        if (q1.size() > 0) t1 = q1[0];
        r0_req    = (q0.size() > 0) && !cool0;
        r0_we     = t0.we;
        r0_addr   = t0.addr;
        r0_wdata  = t0.wdata;
        r1_req    = (q1.size() > 0) && !cool1;
        r1_we     = t1.we;
        r1_addr   = t1.addr;
        r1_wdata  = t1.wdata;
        write_rdy = pickBit(forceWr);
        read_rdy  = pickBit(forceRd);
        read_data = (forceRdData < 0) ? 1'($urandom_range(0, 1)) : forceRdData[0];
    endtask

    task automatic checkOutput();
        logic       eWe, eRe, eWd, eAck0, eAck1, eRd0, eRd1, eErr0, eErr1;
        logic [2:0] eAddr;
        eWe = 0; eRe = 0; eWd = 0; eAddr = 0;
        eAck0 = 0; eAck1 = 0; eRd0 = 0; eRd1 = 0; eErr0 = 0; eErr1 = 0;
        if (mActive && !mFinished) begin
            eAddr = mCur.addr;
            eWd   = mCur.wdata;
            if (mCur.we) eWe = write_rdy;
            else         eRe = read_rdy;
        end
        if (mActive && mFinished) begin
            if (mOwner == 0) begin eAck0 = 1; eRd0 = mRdata; eErr0 = mErr; end
            else             begin eAck1 = 1; eRd1 = mRdata; eErr1 = mErr; end
        end
        check("write_en", write_en, eWe);
        check("read_en", read_en, eRe);
        check("write_address", write_address, eAddr);
        check("read_address", read_address, eAddr);
        check("write_data", write_data, eWd);
        check("r0_ack", r0_ack, eAck0);
        check("r0_rdata", r0_rdata, eRd0);
        check("r0_err", r0_err, eErr0);
        check("r1_ack", r1_ack, eAck1);
        check("r1_rdata", r1_rdata, eRd1);
        check("r1_err", r1_err, eErr1);
        check("busy", busy, mActive);
        check("grant", grant, mLastGrant);
    endtask

    // What the next rising edge does to the transaction-level model
    task automatic advanceModel();
        bit rdy;
        bit c0, c1;
        c0 = 0;
        c1 = 0;
        if (!mActive) begin
            if (r0_req || r1_req) begin
`ifdef ACCESS_ARBITER_RR_EN
                mOwner = (r0_req && r1_req) ? !mLastGrant : !r0_req;
`else
                mOwner = !r0_req;
`endif
                mCur       = mOwner ? q1[0] : q0[0];
                mLastGrant = mOwner;
                mActive    = 1;
                mFinished  = 0;
                mStall     = 0;
            end
        end else if (!mFinished) begin
            rdy = mCur.we ? write_rdy : read_rdy;
            if (rdy) begin
                mFinished = 1;
                mErr      = 0;
                mRdata    = mCur.we ? 1'b0 : read_data;
            end else begin
                mStall++;
                if (mStall >= LIMIT) begin
                    mFinished = 1;
                    mErr      = 1;
                    mRdata    = 0;
                end
            end
        end else begin
            mActive = 0;
            if (mOwner) begin void'(q1.pop_front()); c1 = 1; end
            else        begin void'(q0.pop_front()); c0 = 1; end
        end
        cool0 = c0;
        cool1 = c1;
    endtask

    task automatic stepCycle();
        applyStimulus();
        #1;
        checkOutput();
        advanceModel();
        @(negedge CLK);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic doReset();
        RST = 1;
        r0_req = 0;
        r1_req = 0;
        @(negedge CLK);
        RST = 0;
        mActive    = 0;
        mFinished  = 0;
        mLastGrant = 1;
        mStall     = 0;
        cool0      = 0;
        cool1      = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && !mActive) break;
            stepCycle();
        end
        check("drained", ((q0.size() + q1.size()) == 0) && !mActive, 1'b1);
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        forceWr = 1; forceRd = 1; forceRdData = 0;
        {r0_req, r0_we, r0_addr, r0_wdata} = '0;
        {r1_req, r1_we, r1_addr, r1_wdata} = '0;
        {write_rdy, read_rdy, read_data} = '0;
        RST = 1;
        @(negedge CLK);
        @(negedge CLK);
        doReset();

        $display("[TB] reset state and idle");
        runCycles(2);

        $display("[TB] r0 write addr 4 data 1");
        q0.push_back('{we: 1'b1, addr: 3'd4, wdata: 1'b1});
        runCycles(4);

        $display("[TB] r1 read addr 6");
        forceRdData = 1;
        q1.push_back('{we: 1'b0, addr: 3'd6, wdata: 1'b0});
        runCycles(4);

        $display("[TB] write stalled to the limit");
        forceWr = 0;
        q0.push_back('{we: 1'b1, addr: 3'd2, wdata: 1'b1});
        runCycles(LIMIT + 4);

        $display("[TB] write ready rising at stall cycle 10");
        q0.push_back('{we: 1'b1, addr: 3'd5, wdata: 1'b0});
        runCycles(1 + 9);
        forceWr = 1;
        runCycles(4);

        $display("[TB] simultaneous request after r0 was served");
        q0.push_back('{we: 1'b1, addr: 3'd1, wdata: 1'b1});
        runCycles(4);
        q0.push_back('{we: 1'b1, addr: 3'd3, wdata: 1'b0});
        q1.push_back('{we: 1'b1, addr: 3'd7, wdata: 1'b1});
        runCycles(2);
`ifdef ACCESS_ARBITER_RR_EN
        check("rrPick", grant, 1'b1);
`else
        check("fixedPick", grant, 1'b0);
`endif
        drain();

        $display("[TB] reset during issue");
        forceRd = 0;
        q0.push_back('{we: 1'b0, addr: 3'd2, wdata: 1'b0});
        q1.push_back('{we: 1'b0, addr: 3'd3, wdata: 1'b0});
        runCycles(3);
        check("busyBeforeReset", busy, 1'b1);
        doReset();
        forceRd = 1;
        runCycles(2);
        check("grantAfterReset", grant, 1'b0);
        drain();

        $display("[TB] random traffic");
        forceWr = -1; forceRd = -1; forceRdData = -1;
        for (int i = 0; i < 2000; i++) begin
            if (q0.size() < 3 && $urandom_range(0, 3) == 0)
                q0.push_back(txn_t'($urandom_range(0, 31)));
            if (q1.size() < 3 && $urandom_range(0, 3) == 0)
                q1.push_back(txn_t'($urandom_range(0, 31)));
            stepCycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
